ps2_keyboard_rx: RTL
====================

// Module: ps2_keyboard_rx
// PURPOSE
//  PS/2 keyboard receiver. It decodes 11-bit device-to-host frames into scan codes.
//  It sits directly upstream of the VGA controller and drives its KeyboardInput (oKeyCode)
//  and AdvanceCursor (oKeyValid) inputs. It runs in the iVGA_CLK domain (25 MHz) and oversamples the PS/2 lines.
// PARAMETERS
//  SYNC_STAGES   2      synchroniser depth on iPS2_CLK / iPS2_DAT (>=2)
//  FILTER_LEN    4      consecutive equal samples needed to accept a PS/2 clock level change
//  TIMEOUT_CYC   25000  iVGA_CLK cycles without a PS/2 falling edge before a mid-frame abort (1 ms)
// PORTS
//  iVGA_CLK   in   1  system/pixel clock
//  iRST       in   1  asynchronous, active-high reset
//  iPS2_CLK   in   1  raw PS/2 clock line (async, open-drain, idle 1)
//  iPS2_DAT   in   1  raw PS/2 data line (async, idle 1)
//  oKeyCode   out  8  last accepted make code; held until the next accepted make code
//  oKeyValid  out  1  1-cycle pulse when oKeyCode updates (feeds AdvanceCursor)
//  oExtended  out  1  1 when the current oKeyCode was preceded by 0xE0
//  oFrameErr  out  1  1-cycle pulse on a parity, stop-bit or timeout error
// BEHAVIOUR
//  - One clock; asynchronous, active-high reset: iRST high forces all state to reset immediately, with no clock needed.
//  - Reset: oKeyCode=0, oKeyValid=0, oExtended=0, oFrameErr=0, FSM=IDLE, filtered clock=1, flags clear.
//  - Reset mid-frame aborts the frame silently. No error pulse is produced.
//  - Both PS/2 lines pass through SYNC_STAGES flops. The clock line then passes a glitch filter:
//    the filtered level changes only after FILTER_LEN consecutive samples of the new level.
//  - A sample event is one cycle where the filtered clock goes 1->0. Synchronised data is read in that cycle.
//  - FSM states IDLE, DATA, PARITY, STOP; each transition happens only on a sample event.
//    IDLE:   dat=0 -> DATA with bit count=0. dat=1 -> stay in IDLE (stray edge is ignored, no error).
//    DATA:   shift dat in LSB first. After the 8th bit -> PARITY.
//    PARITY: capture dat -> STOP.
//    STOP:   frame is good if dat=1 and XOR(data,parity)=1 (odd parity). Otherwise raise oFrameErr. Always -> IDLE.
//  - Timeout counter: width $clog2(TIMEOUT_CYC+1). It clears on every sample event and in IDLE, and saturates.
//    If it reaches TIMEOUT_CYC outside IDLE: FSM -> IDLE and oFrameErr pulses.
//    A sample event in the same cycle as the timeout takes priority (no abort).
//  - Good-frame processing happens in the cycle after the STOP sample (latency = 1 cycle):
//    0xE0: set ext_flag. No output.
//    0xF0: set brk_flag. No output.
//    other with brk_flag=1: break code. Clear brk_flag and ext_flag. oKeyCode unchanged, no pulse.
//    other with brk_flag=0: make code. oKeyCode<=byte, oExtended<=ext_flag, oKeyValid=1 for one cycle, clear ext_flag.
//  - An errored frame leaves ext_flag, brk_flag and oKeyCode untouched.
// CONFIGURATION
//  - Macro PS2_REPEAT_FILTER_EN.
//  - Defined: the block keeps held_code and held_vld (reset to 0).
//    A make code equal to held_code while held_vld=1 is suppressed: no oKeyValid pulse, oKeyCode unchanged.
//    Any other make code sets held_code=byte and held_vld=1.
//    A break code whose byte equals held_code clears held_vld.
//  - Not defined: every make code, including typematic repeats, pulses oKeyValid.
// STRUCTURE
//  - Definitions in Defs.txt, the shared defines file:
//    PS2_EXT_CODE=8'hE0 and PS2_BRK_CODE=8'hF0.
//    FSM state encodings PS2_IDLE, PS2_DATA, PS2_PARITY, PS2_STOP.
//  - Sub-module ps2_line_filter: parameterised synchroniser plus glitch filter.
//    Outputs the filtered level and a fall pulse. It is instantiated for the clock line.
//    The data line uses the synchroniser only.
// TESTING (PS/2 clock 12.5 kHz unless stated)
//  1. Frame 0x1C, good parity -> one oKeyValid pulse, oKeyCode=0x1C, oExtended=0, no oFrameErr.
//  2. Then F0,1C -> no oKeyValid pulse, oKeyCode stays 0x1C, no error.
//  3. E0,75 then 1C -> pulse with oKeyCode=0x75 and oExtended=1, then pulse with oKeyCode=0x1C and oExtended=0.
//  4. 0x1C with wrong parity bit, then 0x1C with a stop bit of 0 -> two oFrameErr pulses, no oKeyValid.
//     Next good 0x29 -> oKeyCode=0x29.
//  5. Start bit plus 4 data bits, then clock held high -> oFrameErr exactly TIMEOUT_CYC cycles after the last fall.
//     A 2-cycle low glitch on iPS2_CLK is ignored. A following good 0x29 decodes.
//  6. Sequence 1C,1C,1C,F0,1C,1C:
//     PS2_REPEAT_FILTER_EN defined -> 2 pulses.
//     PS2_REPEAT_FILTER_EN undefined -> 4 pulses.
//     Assert iRST mid-frame -> outputs reset immediately with no error.

Source files
------------

// File: rtl/ps2_keyboard_rx_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: special scan codes,
// FSM state encodings and the frame parity helper.
package ps2_keyboard_rx_pkg;

  localparam logic [7:0] PS2_EXT_CODE = 8'hE0;
  localparam logic [7:0] PS2_BRK_CODE = 8'hF0;

  localparam logic [1:0] PS2_IDLE   = 2'd0;
  localparam logic [1:0] PS2_DATA   = 2'd1;
  localparam logic [1:0] PS2_PARITY = 2'd2;
  localparam logic [1:0] PS2_STOP   = 2'd3;

  // PS/2 uses odd parity over the eight data bits plus the parity bit.
  function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchroniser plus glitch filter for one PS/2 line. The filtered level moves
// only after FILTER_LEN consecutive synchronised samples of the new level.
module ps2_line_filter #(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_LEN  = 4,
  parameter logic IDLE_LEVEL  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   fall_q, fall_d;
  logic                   sample;

  assign sample = sync_q[SYNC_STAGES-1];

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], line_i};
    level_d = level_q;
    cnt_d   = '0;
    fall_d  = 1'b0;
    if (sample != level_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        level_d = sample;
        fall_d  = ~sample;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // NOTE: the synchroniser resets to the idle line level so that leaving
  // reset never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= {SYNC_STAGES{IDLE_LEVEL}};
      cnt_q   <= '0;
      level_q <= IDLE_LEVEL;
      fall_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: decodes device-to-host frames into make codes.
// Optional typematic-repeat suppression is built when PS2_REPEAT_FILTER_EN is defined.
module ps2_keyboard_rx
  import ps2_keyboard_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 25000
) (
  input  logic       iVGA_CLK,
  input  logic       iRST,
  input  logic       iPS2_CLK,
  input  logic       iPS2_DAT,
  output logic [7:0] oKeyCode,
  output logic       oKeyValid,
  output logic       oExtended,
  output logic       oFrameErr
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic                   ps2_clk_level, ps2_clk_fall, sample_evt;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  logic                   dat;

  logic [1:0]    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          frame_vld_q, frame_vld_d;
  logic          frame_err_q, frame_err_d;

  logic [7:0] key_code_q, key_code_d;
  logic       key_valid_q, key_valid_d;
  logic       extended_q, extended_d;
  logic       ext_flag_q, ext_flag_d;
  logic       brk_flag_q, brk_flag_d;
  logic       make_emit;
`ifdef PS2_REPEAT_FILTER_EN
  logic [7:0] held_code_q, held_code_d;
  logic       held_vld_q, held_vld_d;
`endif

  ps2_line_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN),
    .IDLE_LEVEL  (1'b1)
  ) u_clk_filter (
    .clk     (iVGA_CLK),
    .rst     (iRST),
    .line_i  (iPS2_CLK),
    .level_o (ps2_clk_level),
    .fall_o  (ps2_clk_fall)
  );

  assign sample_evt = ps2_clk_fall & ~ps2_clk_level;
  assign dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], iPS2_DAT};
  assign dat        = dat_sync_q[SYNC_STAGES-1];

  // Frame FSM and inter-edge timeout; a sample event always beats the timeout.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    frame_vld_d = 1'b0;
    frame_err_d = 1'b0;

    if (sample_evt || state_q == PS2_IDLE)       tmo_cnt_d = '0;
    else if (tmo_cnt_q != TW'(TIMEOUT_CYC))      tmo_cnt_d = tmo_cnt_q + TW'(1);
    else                                         tmo_cnt_d = tmo_cnt_q;

    if (sample_evt) begin
      case (state_q)
        PS2_IDLE: begin
          if (!dat) begin
            state_d   = PS2_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        PS2_DATA: begin
          shift_d   = {dat, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PS2_PARITY;
        end
        PS2_PARITY: begin
          parity_d = dat;
          state_d  = PS2_STOP;
        end
        default: begin
          if (dat && ps2_parity_ok(shift_q, parity_q)) frame_vld_d = 1'b1;
          else                                          frame_err_d = 1'b1;
          state_d = PS2_IDLE;
        end
      endcase
    end else if (state_q != PS2_IDLE && tmo_cnt_q == TW'(TIMEOUT_CYC)) begin
      state_d     = PS2_IDLE;
      frame_err_d = 1'b1;
    end
  end

  // Good-frame decode, one cycle after the stop sample; shift_q still holds the byte.
  always_comb begin
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    extended_d  = extended_q;
    ext_flag_d  = ext_flag_q;
    brk_flag_d  = brk_flag_q;
`ifdef PS2_REPEAT_FILTER_EN
    held_code_d = held_code_q;
    held_vld_d  = held_vld_q;
    make_emit   = !(held_vld_q && shift_q == held_code_q);
`else
    make_emit   = 1'b1;
`endif
    if (frame_vld_q) begin
      if (shift_q == PS2_EXT_CODE) begin
        ext_flag_d = 1'b1;
      end else if (shift_q == PS2_BRK_CODE) begin
        brk_flag_d = 1'b1;
      end else if (brk_flag_q) begin
        brk_flag_d = 1'b0;
        ext_flag_d = 1'b0;
`ifdef PS2_REPEAT_FILTER_EN
        if (shift_q == held_code_q) held_vld_d = 1'b0;
`endif
      end else begin
        ext_flag_d = 1'b0;
        if (make_emit) begin
          key_code_d  = shift_q;
          extended_d  = ext_flag_q;
          key_valid_d = 1'b1;
`ifdef PS2_REPEAT_FILTER_EN
          held_code_d = shift_q;
          held_vld_d  = 1'b1;
`endif
        end
      end
    end
  end

  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      dat_sync_q  <= '1;
      state_q     <= PS2_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      tmo_cnt_q   <= '0;
      frame_vld_q <= 1'b0;
      frame_err_q <= 1'b0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      extended_q  <= 1'b0;
      ext_flag_q  <= 1'b0;
      brk_flag_q  <= 1'b0;
`ifdef PS2_REPEAT_FILTER_EN
      held_code_q <= '0;
      held_vld_q  <= 1'b0;
`endif
    end else begin
      dat_sync_q  <= dat_sync_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      tmo_cnt_q   <= tmo_cnt_d;
      frame_vld_q <= frame_vld_d;
      frame_err_q <= frame_err_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      extended_q  <= extended_d;
      ext_flag_q  <= ext_flag_d;
      brk_flag_q  <= brk_flag_d;
`ifdef PS2_REPEAT_FILTER_EN
      held_code_q <= held_code_d;
      held_vld_q  <= held_vld_d;
`endif
    end
  end

  assign oKeyCode  = key_code_q;
  assign oKeyValid = key_valid_q;
  assign oExtended = extended_q;
  assign oFrameErr = frame_err_q;

endmodule
